// File: rtl/saper_pkg.sv
// Shared types and sizes for the Saper play-screen timer.
package saper_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE,
    TMR_RUNNING,
    TMR_PAUSED,
    TMR_STOPPED
  } timer_state_t;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4;
  localparam int SEC_W      = 10;

endpackage

// File: rtl/bcd_digit_ctr.sv
// One BCD digit (0..9) with increment, synchronous clear and a saturation hold.
// carry is combinational so a chain of digits ripples within one cycle.
module bcd_digit_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic       hold_at_max,
  output logic [3:0] digit,
  output logic       carry
);

  logic step;

  assign step  = inc & ~hold_at_max;
  assign carry = step && (digit == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       digit <= '0;
    else if (clr)  digit <= '0;
    else if (step) digit <= carry ? 4'd0 : digit + 4'd1;
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Elapsed-time controller: start/pause/stop/clear FSM, 1 Hz prescaler,
// saturating binary seconds counter and a parallel BCD digit chain.
module game_timer_ctrl
  import saper_pkg::*;
#(
  parameter int TICK_DIV    = 65_000_000,
  parameter int MAX_SECONDS = 999,
  parameter int PRESC_W     = $clog2(TICK_DIV)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        clear,
  output logic        sec_tick,
  output logic        running,
  output logic        frozen,
  output logic        saturated,
  output logic [9:0]  seconds_bin,
  output logic [11:0] seconds_bcd
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]   SEC_MAX    = SEC_W'(MAX_SECONDS);

  timer_state_t                        state_q, state_d;
  logic [PRESC_W-1:0]                  presc_q, presc_d;
  logic [SEC_W-1:0]                    count_q, count_d;
  logic                                tick, at_max, count_inc;
  logic [BCD_DIGITS:0]                 carry;
  logic [BCD_DIGITS-1:0][BCD_W-1:0]    bcd_q;
  logic                                bcd_carry_unused;

  // clear > stop > pause > start
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = TMR_IDLE;
    end else begin
      case (state_q)
        TMR_IDLE:    if (start && !pause) state_d = TMR_RUNNING;
        TMR_RUNNING: if (stop)            state_d = TMR_STOPPED;
                     else if (pause)      state_d = TMR_PAUSED;
        TMR_PAUSED:  if (stop)            state_d = TMR_STOPPED;
                     else if (!pause)     state_d = TMR_RUNNING;
        TMR_STOPPED: state_d = TMR_STOPPED;
        default:     state_d = TMR_IDLE;
      endcase
    end
  end

  // The tick cycle is still counted when stop/pause arrive with it; only clear cancels it.
  assign tick      = (state_q == TMR_RUNNING) && (presc_q == PRESC_LAST) && !clear;
  assign at_max    = (count_q == SEC_MAX);
  assign count_inc = tick && !at_max;

  // Prescaler parks at 0 in IDLE and holds its partial second while PAUSED/STOPPED.
  always_comb begin
    presc_d = presc_q;
    if (clear || state_q == TMR_IDLE)
      presc_d = '0;
    else if (state_q == TMR_RUNNING)
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
  end

  always_comb begin
    count_d = count_q;
    if (clear)          count_d = '0;
    else if (count_inc) count_d = count_q + SEC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TMR_IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      sec_tick  <= 1'b0;
      running   <= 1'b0;
      frozen    <= 1'b0;
      saturated <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      sec_tick  <= tick;
      running   <= (state_d == TMR_RUNNING);
      frozen    <= (state_d == TMR_STOPPED);
      saturated <= (count_d == SEC_MAX);
    end
  end

  assign carry[0] = count_inc;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    bcd_digit_ctr u_digit (
      .clk         (clk),
      .rst         (rst),
      .inc         (carry[i]),
      .clr         (clear),
      .hold_at_max (at_max),
      .digit       (bcd_q[i]),
      .carry       (carry[i+1])
    );
  end

  // MAX_SECONDS <= 999, so the hundreds digit never carries out.
  assign bcd_carry_unused = carry[BCD_DIGITS];

  assign seconds_bin = count_q;
  assign seconds_bcd = bcd_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: directed scenarios plus random stimulus against a
// model that derives seconds as floor(cycles spent running / TICK_DIV).
module tb_game_timer_ctrl;

  localparam int TICK_DIV = 10;
  localparam int MAX_A    = 999;
  localparam int MAX_B    = 12;

  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, pause = 1'b0, stop = 1'b0, clear = 1'b0;

  logic tick_a, run_a, frz_a, sat_a, tick_b, run_b, frz_b, sat_b;
  logic [9:0]  bin_a, bin_b;
  logic [11:0] bcd_a, bcd_b;
  logic [25:0] obs_a, obs_b;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mode_t;
  mode_t mode = M_IDLE;
  int    run_cycles = 0;
  bit    m_tick = 1'b0;

  always #5 clk = ~clk;

  game_timer_ctrl #(.TICK_DIV(TICK_DIV), .MAX_SECONDS(MAX_A)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .clear(clear),
    .sec_tick(tick_a), .running(run_a), .frozen(frz_a), .saturated(sat_a),
    .seconds_bin(bin_a), .seconds_bcd(bcd_a));

  game_timer_ctrl #(.TICK_DIV(TICK_DIV), .MAX_SECONDS(MAX_B)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .clear(clear),
    .sec_tick(tick_b), .running(run_b), .frozen(frz_b), .saturated(sat_b),
    .seconds_bin(bin_b), .seconds_bcd(bcd_b));

  assign obs_a = {tick_a, run_a, frz_a, sat_a, bin_a, bcd_a};
  assign obs_b = {tick_b, run_b, frz_b, sat_b, bin_b, bcd_b};

  function automatic logic [25:0] expect_vec(input int max_s);
    int s;
    s = run_cycles / TICK_DIV;
    if (s > max_s) s = max_s;
    return {m_tick, mode == M_RUN, mode == M_DONE, s == max_s, 10'(s),
            4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // One clock edge; model follows the game rules with the inputs present at the edge.
  task automatic cyc();
    bit t;
    t = (mode == M_RUN) && ((run_cycles + 1) % TICK_DIV == 0) && !clear;
    @(posedge clk);
    m_tick = t;
    if (clear) begin
      mode = M_IDLE;
      run_cycles = 0;
    end else begin
      if (mode == M_RUN) run_cycles++;
      case (mode)
        M_IDLE: if (start && !pause) mode = M_RUN;
        M_RUN:  if (stop) mode = M_DONE; else if (pause) mode = M_HOLD;
        M_HOLD: if (stop) mode = M_DONE; else if (!pause) mode = M_RUN;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    start = 0; pause = 0; stop = 0; clear = 0;
    rst = 1'b1;
    #2;
    mode = M_IDLE; run_cycles = 0; m_tick = 0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (13) cyc();
    rst = 1'b1;
    #1;
    total++; if (obs_a !== 26'd0) begin bad++; $display("FAIL reset_async_a: got %h want %h", obs_a, 26'd0); end
    total++; if (obs_b !== 26'd0) begin bad++; $display("FAIL reset_async_b: got %h want %h", obs_b, 26'd0); end
    #1;
    mode = M_IDLE; run_cycles = 0; m_tick = 0;
    rst = 1'b0;
    #1;
    repeat (5) begin
      cyc();
      total++; if (obs_a !== expect_vec(MAX_A)) begin bad++; $display("FAIL idle_hold: got %h want %h", obs_a, expect_vec(MAX_A)); end
    end
  endtask

  task automatic test_count();
    do_reset();
    start = 1; cyc(); start = 0;
    total++; if (run_a !== 1'b1) begin bad++; $display("FAIL start_running: got %b want 1", run_a); end
    repeat (250) begin
      cyc();
      total++; if (obs_a !== expect_vec(MAX_A)) begin bad++; $display("FAIL count_a: got %h want %h", obs_a, expect_vec(MAX_A)); end
      total++; if (obs_b !== expect_vec(MAX_B)) begin bad++; $display("FAIL count_b: got %h want %h", obs_b, expect_vec(MAX_B)); end
    end
    total++; if (bcd_a !== 12'h025 || bin_a !== 10'd25) begin bad++; $display("FAIL count_25: got %h/%0d want 025/25", bcd_a, bin_a); end
    total++; if (tick_a !== 1'b1) begin bad++; $display("FAIL tick_25: got %b want 1", tick_a); end
    total++; if (bin_b !== 10'd12 || sat_b !== 1'b1 || tick_b !== 1'b1) begin bad++; $display("FAIL sat_hold: got %0d sat=%b tick=%b want 12 1 1", bin_b, sat_b, tick_b); end
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (14) cyc();
    pause = 1;
    repeat (30) begin
      cyc();
      total++; if (obs_a !== expect_vec(MAX_A) || bin_a !== 10'd1) begin bad++; $display("FAIL pause_hold: got %h want %h", obs_a, expect_vec(MAX_A)); end
    end
    pause = 0;
    n = 0;
    do begin
      cyc(); n++;
      total++; if (obs_a !== expect_vec(MAX_A)) begin bad++; $display("FAIL pause_resume: got %h want %h", obs_a, expect_vec(MAX_A)); end
    end while (tick_a !== 1'b1 && n < 20);
    total++; if (n != 6) begin bad++; $display("FAIL resume_latency: got %0d want 6", n); end
  endtask

  task automatic test_bcd_carry();
    do_reset();
    start = 1; cyc(); start = 0;
    for (int c = 1; c <= 1000; c++) begin
      cyc();
      total++; if (obs_a !== expect_vec(MAX_A)) begin bad++; $display("FAIL bcd_run: got %h want %h", obs_a, expect_vec(MAX_A)); end
      if (c == 100) begin
        total++; if (bcd_a !== 12'h010) begin bad++; $display("FAIL bcd_10: got %h want 010", bcd_a); end
      end
    end
    total++; if (bcd_a !== 12'h100 || bin_a !== 10'd100) begin bad++; $display("FAIL bcd_100: got %h/%0d want 100/100", bcd_a, bin_a); end
  endtask

  task automatic test_stop_tick();
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (79) cyc();
    stop = 1; cyc(); stop = 0;
    total++; if (frz_a !== 1'b1 || run_a !== 1'b0 || bin_a !== 10'd8 || tick_a !== 1'b1) begin bad++; $display("FAIL stop_on_tick: got %h want frozen count 8", obs_a); end
    start = 1;
    repeat (15) begin
      cyc();
      total++; if (obs_a !== expect_vec(MAX_A) || bin_a !== 10'd8) begin bad++; $display("FAIL stopped_hold: got %h want %h", obs_a, expect_vec(MAX_A)); end
    end
    start = 0;
    clear = 1; cyc(); clear = 0;
    total++; if (obs_a !== 26'd0) begin bad++; $display("FAIL stop_clear: got %h want %h", obs_a, 26'd0); end
  endtask

  task automatic test_clear_combo();
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (23) cyc();
    clear = 1; stop = 1; start = 1; cyc();
    clear = 0; stop = 0; start = 0;
    total++; if (obs_a !== 26'd0) begin bad++; $display("FAIL clear_wins: got %h want %h", obs_a, 26'd0); end
    cyc();
    total++; if (obs_a !== expect_vec(MAX_A)) begin bad++; $display("FAIL clear_after: got %h want %h", obs_a, expect_vec(MAX_A)); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      clear = ($urandom_range(0, 99) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      cyc();
      total++; if (obs_a !== expect_vec(MAX_A)) begin bad++; $display("FAIL random_a: got %h want %h", obs_a, expect_vec(MAX_A)); end
      total++; if (obs_b !== expect_vec(MAX_B)) begin bad++; $display("FAIL random_b: got %h want %h", obs_b, expect_vec(MAX_B)); end
    end
    start = 0; stop = 0; clear = 0; pause = 0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_bcd_carry();
    test_stop_tick();
    test_clear_combo();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
